// File: rtl/pr_pkg.sv
// Shared definitions for the priority-request grant path.
//   pr_q_state_t   : occupancy state of the single-entry grant register.
//   pr_onehot2idx  : one-hot to binary index conversion (up to 64 lines),
//                    shared with other priority-encoder users.
package pr_pkg;

  typedef enum logic {
    PRQ_EMPTY = 1'b0,
    PRQ_FULL  = 1'b1
  } pr_q_state_t;

  // OR-reduction of the indices of all set bits; exact for a one-hot input,
  // returns 0 for an all-zero input.
  function automatic logic [5:0] pr_onehot2idx(input logic [63:0] onehot);
    logic [5:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (onehot[i]) idx = idx | 6'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pr_onehot_pick.sv
// Combinational highest-index-wins selector.
//   cand : candidate request vector
//   pick : one-hot of the highest set bit of cand; all zeros when cand == 0
module pr_onehot_pick #(
  parameter int W = 8
) (
  input  logic [W-1:0] cand,
  output logic [W-1:0] pick
);

  // Scanning upward and overwriting leaves only the highest set bit.
  always_comb begin
    pick = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (cand[i]) begin
        pick    = '0;
        pick[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pr_grant_queue.sv
// Sticky request capture plus registered priority grant.
// Request pulses accumulate in a pending register; the highest-priority
// pending, enabled line is loaded into a single-entry grant register and
// offered on a valid/ready handshake. The granted bit is retired from
// pending at the moment it is loaded.
//   clk, rst      : clock, asynchronous active-high reset
//   req_in        : single-cycle request pulses
//   mask          : per-line enable (0 = hold pending, never select)
//   grant_valid   : grant register occupied
//   grant_ready   : consumer accepts when grant_valid & grant_ready
//   grant_onehot  : registered one-hot grant (0 when not valid)
//   grant_idx     : registered binary index of grant_onehot (0 when not valid)
//   pending       : sticky pending register
//   overflow      : sticky flag, request coalesced into an already-pending bit
//   clr_ovf       : synchronous clear of overflow (a new event wins)
module pr_grant_queue
  import pr_pkg::*;
#(
  parameter  int wordLen = 8,
  localparam int IDX_W   = (wordLen > 1) ? $clog2(wordLen) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [wordLen-1:0] req_in,
  input  logic [wordLen-1:0] mask,
  output logic               grant_valid,
  input  logic               grant_ready,
  output logic [wordLen-1:0] grant_onehot,
  output logic [IDX_W-1:0]   grant_idx,
  output logic [wordLen-1:0] pending,
  output logic               overflow,
  input  logic               clr_ovf
);

  pr_q_state_t        state, state_nx;
  logic [wordLen-1:0] merged;
  logic [wordLen-1:0] cand;
  logic [wordLen-1:0] pick;
  logic [wordLen-1:0] retire;
  logic [wordLen-1:0] pending_nx;
  logic               accept;
  logic               load;
  logic               ovf_event;
  logic               ovf_nx;

  assign merged      = pending | req_in;
  assign cand        = merged & mask;
  assign grant_valid = (state == PRQ_FULL);
  assign accept      = grant_valid & grant_ready;

  pr_onehot_pick #(
    .W (wordLen)
  ) u_pick (
    .cand (cand),
    .pick (pick)
  );

  always_comb begin
    state_nx   = state;
    load       = 1'b0;
    retire     = '0;
    pending_nx = merged;
    ovf_event  = 1'b0;
    ovf_nx     = overflow;

    case (state)
      PRQ_EMPTY: begin
        if (cand != '0) begin
          load     = 1'b1;
          state_nx = PRQ_FULL;
        end
      end
      PRQ_FULL: begin
        if (accept) begin
          if (cand != '0) begin
            load     = 1'b1;
            state_nx = PRQ_FULL;
          end else begin
            state_nx = PRQ_EMPTY;
          end
        end
      end
      default: state_nx = PRQ_EMPTY;
    endcase

    if (load) retire = pick;
    pending_nx = merged & ~retire;

    // A repeat request on a bit that this cycle's load retires is consumed
    // by that load rather than coalesced, so it is not an overflow.
    ovf_event = |(req_in & pending & ~retire);
    if (ovf_event)    ovf_nx = 1'b1;
    else if (clr_ovf) ovf_nx = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= PRQ_EMPTY;
      pending      <= '0;
      grant_onehot <= '0;
      grant_idx    <= '0;
      overflow     <= 1'b0;
    end else begin
      state    <= state_nx;
      pending  <= pending_nx;
      overflow <= ovf_nx;
      if (load) begin
        grant_onehot <= pick;
        grant_idx    <= IDX_W'(pr_onehot2idx(64'(pick)));
      end else if (accept) begin
        grant_onehot <= '0;
        grant_idx    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pr_grant_queue.sv
module tb_pr_grant_queue;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] req_in = '0;
  logic [W-1:0] mask = '1;
  logic         grant_ready = 1'b0;
  logic         clr_ovf = 1'b0;
  logic         grant_valid;
  logic [W-1:0] grant_onehot;
  logic [2:0]   grant_idx;
  logic [W-1:0] pending;
  logic         overflow;

  int n_checks = 0;
  int n_fail   = 0;

  pr_grant_queue #(.wordLen(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_in       (req_in),
    .mask         (mask),
    .grant_valid  (grant_valid),
    .grant_ready  (grant_ready),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .pending      (pending),
    .overflow     (overflow),
    .clr_ovf      (clr_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic [7:0] msk;
    logic       rdy;
    logic       clr;
    logic       v;
    logic [7:0] oh;
    logic [2:0] idx;
    logic [7:0] pend;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [7:0] req, input logic [7:0] msk, input logic rdy,
                     input logic clr, input logic v, input logic [7:0] oh,
                     input logic [2:0] idx, input logic [7:0] pend, input logic ovf);
    vec_t t;
    t.req = req; t.msk = msk; t.rdy = rdy; t.clr = clr;
    t.v = v; t.oh = oh; t.idx = idx; t.pend = pend; t.ovf = ovf;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic v, input logic [7:0] oh,
                           input logic [2:0] idx, input logic [7:0] pend, input logic ovf);
    check({tag, ".valid"},    int'(grant_valid),  int'(v));
    check({tag, ".onehot"},   int'(grant_onehot), int'(oh));
    check({tag, ".idx"},      int'(grant_idx),    int'(idx));
    check({tag, ".pending"},  int'(pending),      int'(pend));
    check({tag, ".overflow"}, int'(overflow),     int'(ovf));
  endtask

  // Called at posedge+1: drive, wait for the next edge, sample 1ns later.
  task automatic drive_step(input logic [7:0] req, input logic [7:0] msk,
                            input logic rdy, input logic clr);
    req_in = req; mask = msk; grant_ready = rdy; clr_ovf = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_in = '0; mask = '1; grant_ready = 1'b0; clr_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Reference model: set of pending line numbers and the held grant index.
  bit pm[W];
  int held;
  bit ovf_m;

  task automatic model_step(input logic [7:0] req, input logic [7:0] msk,
                            input logic rdy, input logic clr);
    bit merged[W];
    int choose;
    bit fire;
    bit ev;
    choose = -1;
    ev = 0;
    for (int i = 0; i < W; i++) merged[i] = pm[i] | req[i];
    for (int i = W - 1; i >= 0; i--) begin
      if (choose < 0 && merged[i] && msk[i]) choose = i;
    end
    fire = (held < 0 || rdy) && (choose >= 0);
    for (int i = 0; i < W; i++) begin
      if (req[i] && pm[i] && !(fire && i == choose)) ev = 1;
    end
    if (fire) begin
      held = choose;
      merged[choose] = 0;
    end else if (rdy && held >= 0) begin
      held = -1;
    end
    for (int i = 0; i < W; i++) pm[i] = merged[i];
    if (ev) ovf_m = 1;
    else if (clr) ovf_m = 0;
  endtask

  function automatic logic [7:0] model_pend();
    logic [7:0] p;
    for (int i = 0; i < W; i++) p[i] = pm[i];
    return p;
  endfunction

  initial begin
    // Single lines first, then the test plan sequences.
    // 10 idle cycles
    for (int i = 0; i < 10; i++) add(8'h00, 8'hFF, 1, 0, 0, 8'h00, 0, 8'h00, 0);
    // single pulse
    add(8'h10, 8'hFF, 1, 0, 1, 8'h10, 4, 8'h00, 0);
    add(8'h00, 8'hFF, 1, 0, 0, 8'h00, 0, 8'h00, 0);
    // A5 burst
    add(8'hA5, 8'hFF, 1, 0, 1, 8'h80, 7, 8'h25, 0);
    add(8'h00, 8'hFF, 1, 0, 1, 8'h20, 5, 8'h05, 0);
    add(8'h00, 8'hFF, 1, 0, 1, 8'h04, 2, 8'h01, 0);
    add(8'h00, 8'hFF, 1, 0, 1, 8'h01, 0, 8'h00, 0);
    add(8'h00, 8'hFF, 1, 0, 0, 8'h00, 0, 8'h00, 0);
    // all lines at once
    add(8'hFF, 8'hFF, 1, 0, 1, 8'h80, 7, 8'h7F, 0);
    add(8'h00, 8'hFF, 1, 0, 1, 8'h40, 6, 8'h3F, 0);
    add(8'h00, 8'hFF, 1, 0, 1, 8'h20, 5, 8'h1F, 0);
    add(8'h00, 8'hFF, 1, 0, 1, 8'h10, 4, 8'h0F, 0);
    add(8'h00, 8'hFF, 1, 0, 1, 8'h08, 3, 8'h07, 0);
    add(8'h00, 8'hFF, 1, 0, 1, 8'h04, 2, 8'h03, 0);
    add(8'h00, 8'hFF, 1, 0, 1, 8'h02, 1, 8'h01, 0);
    add(8'h00, 8'hFF, 1, 0, 1, 8'h01, 0, 8'h00, 0);
    add(8'h00, 8'hFF, 1, 0, 0, 8'h00, 0, 8'h00, 0);
    // stall: grant held while higher priority arrives
    add(8'h03, 8'hFF, 0, 0, 1, 8'h02, 1, 8'h01, 0);
    add(8'h00, 8'hFF, 0, 0, 1, 8'h02, 1, 8'h01, 0);
    add(8'h00, 8'hFF, 0, 0, 1, 8'h02, 1, 8'h01, 0);
    add(8'h80, 8'hFF, 0, 0, 1, 8'h02, 1, 8'h81, 0);
    add(8'h00, 8'hFF, 1, 0, 1, 8'h80, 7, 8'h01, 0);
    add(8'h00, 8'hFF, 1, 0, 1, 8'h01, 0, 8'h00, 0);
    add(8'h00, 8'hFF, 1, 0, 0, 8'h00, 0, 8'h00, 0);
    // masked lines accumulate, then release
    add(8'h0C, 8'hF0, 1, 0, 0, 8'h00, 0, 8'h0C, 0);
    add(8'h00, 8'hF0, 1, 0, 0, 8'h00, 0, 8'h0C, 0);
    add(8'h00, 8'hFF, 1, 0, 1, 8'h08, 3, 8'h04, 0);
    add(8'h00, 8'hFF, 1, 0, 1, 8'h04, 2, 8'h00, 0);
    add(8'h00, 8'hFF, 1, 0, 0, 8'h00, 0, 8'h00, 0);
    // mask cleared while FULL does not revoke
    add(8'h20, 8'hFF, 0, 0, 1, 8'h20, 5, 8'h00, 0);
    add(8'h00, 8'h00, 0, 0, 1, 8'h20, 5, 8'h00, 0);
    add(8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00, 0);
    // overflow set / clear / set-wins
    add(8'h04, 8'h00, 1, 0, 0, 8'h00, 0, 8'h04, 0);
    add(8'h04, 8'h00, 1, 0, 0, 8'h00, 0, 8'h04, 1);
    add(8'h00, 8'h00, 1, 1, 0, 8'h00, 0, 8'h04, 0);
    add(8'h04, 8'h00, 1, 1, 0, 8'h00, 0, 8'h04, 1);
    add(8'h00, 8'h00, 1, 1, 0, 8'h00, 0, 8'h04, 0);
    // grant loads, then same line re-arms pending without overflow
    add(8'h00, 8'hFF, 0, 0, 1, 8'h04, 2, 8'h00, 0);
    add(8'h04, 8'hFF, 0, 0, 1, 8'h04, 2, 8'h04, 0);

    do_reset();
    check_all("reset", 0, 8'h00, 0, 8'h00, 0);

    foreach (vecs[k]) begin
      drive_step(vecs[k].req, vecs[k].msk, vecs[k].rdy, vecs[k].clr);
      check_all($sformatf("vec%0d", k), vecs[k].v, vecs[k].oh, vecs[k].idx,
                vecs[k].pend, vecs[k].ovf);
    end

    // Asynchronous reset mid-transfer: outputs clear without a clock edge.
    req_in = '0; mask = '1; grant_ready = 1'b0;
    #2 rst = 1'b1;
    #1 check_all("async_rst", 0, 8'h00, 0, 8'h00, 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      drive_step(8'h00, 8'hFF, 1, 0);
      check_all("no_retry", 0, 8'h00, 0, 8'h00, 0);
    end

    // Randomized phase against the reference model.
    do_reset();
    for (int i = 0; i < W; i++) pm[i] = 0;
    held = -1;
    ovf_m = 0;
    for (int n = 0; n < 600; n++) begin
      logic [7:0] r, m;
      logic rd, c;
      r  = 8'($urandom) & 8'($urandom) & 8'($urandom);
      m  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      rd = ($urandom_range(0, 2) != 0);
      c  = ($urandom_range(0, 7) == 0);
      drive_step(r, m, rd, c);
      model_step(r, m, rd, c);
      check_all($sformatf("rnd%0d", n), held >= 0,
                (held >= 0) ? 8'(1 << held) : 8'h00,
                (held >= 0) ? 3'(held) : 3'd0,
                model_pend(), ovf_m);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
